decrypting_entity: RTL and testbench

ElGamal decryption engine, the receiving end of `encrypting_entity`. It accepts a ciphertext pair (c1 = `output_a`, c2 = `output_b` of the encryptor), the modulus p and the decryptor's private key a. It returns m = c2 · c1^(p−1−a) mod p. Modular inversion is avoided through Fermat's little theorem. The block is self-contained: it uses an internal bit-serial modular multiplier and a fixed-iteration square-and-multiply exponentiator, and it sits on AXI-stream links next to the encrypting entity.

---
 rtl/decrypting_entity.sv | 258 +++++++++++++++++++++++++
 tb/tb_decrypting_entity.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/decrypting_entity.sv
// ---------------------------------------------------------------------------
// decrypting_entity
//   ElGamal decryption engine: m = c2 * c1^(p-1-a) mod p.
//   The inverse of c1^a is obtained through Fermat's little theorem, so the
//   datapath is one bit-serial modular multiplier. A fixed-iteration
//   square-and-multiply exponentiator drives that multiplier.
//
// Ports
//   clk, rst                       clock (rising edge), async active-high reset
//   input_p_*   (SIZE)             prime modulus p           (AXI-stream sink)
//   input_key_* (SIZE)             private key a             (AXI-stream sink)
//   input_a_*   (SIZE)             ciphertext c1             (AXI-stream sink)
//   input_b_*   (SIZE)             ciphertext c2             (AXI-stream sink)
//   output_m_*  (SIZE)             recovered message m       (AXI-stream source)
//   output_err                     qualifies output_m_tdata, 1 = operands rejected
//
// State | meaning
//   IDLE  | waiting for all four input streams to be valid together
//   CHECK | operand range check, set up exponent e = p-1-a
//   SQR   | t = acc*acc mod p                     (SIZE cycles)
//   MUL   | u = t*c1 mod p, always run            (SIZE cycles)
//   NEXT  | acc = e[idx] ? u : t, step bit index
//   FINAL | m = c2*acc mod p                      (SIZE cycles)
//   DONE  | result presented until output handshake
// ---------------------------------------------------------------------------
module decrypting_entity #(
   parameter int SIZE = 64
) (
   input  logic            clk,
   input  logic            rst,

   input  logic [SIZE-1:0] input_p_tdata,
   input  logic            input_p_tvalid,
   output logic            input_p_tready,

   input  logic [SIZE-1:0] input_key_tdata,
   input  logic            input_key_tvalid,
   output logic            input_key_tready,

   input  logic [SIZE-1:0] input_a_tdata,
   input  logic            input_a_tvalid,
   output logic            input_a_tready,

   input  logic [SIZE-1:0] input_b_tdata,
   input  logic            input_b_tvalid,
   output logic            input_b_tready,

   output logic [SIZE-1:0] output_m_tdata,
   output logic            output_m_tvalid,
   input  logic            output_m_tready,

   output logic            output_err
);

   localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(SIZE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_SQR,
      S_MUL,
      S_NEXT,
      S_FINAL,
      S_DONE
   } state_t;

   state_t            state_q;
   logic [SIZE-1:0]   p_q;
   logic [SIZE-1:0]   e_q;       // holds key a until CHECK, exponent afterwards
   logic [SIZE-1:0]   c1_q;
   logic [SIZE-1:0]   c2_q;
   logic [SIZE-1:0]   acc_q;
   logic [SIZE-1:0]   t_q;
   logic [SIZE-1:0]   u_q;
   logic [SIZE-1:0]   r_q;       // multiplier partial remainder
   logic [IDX_W-1:0]  cnt_q;     // multiplier bit counter, counts down
   logic [IDX_W-1:0]  idx_q;     // exponent bit index, counts down
   logic [SIZE-1:0]   m_q;
   logic              err_q;
   logic              tvalid_q;

   logic              accept;
   logic              bad_ops;

   logic [SIZE-1:0]   mul_x;
   logic [SIZE-1:0]   mul_y;
   logic [SIZE:0]     dbl;
   logic [SIZE-1:0]   dbl_red;
   logic [SIZE:0]     sum;
   logic [SIZE-1:0]   sum_red;
   logic [SIZE-1:0]   r_nxt;

   // Joint handshake: all four streams transfer on the same edge or none does.
   always_comb begin
      accept = (state_q == S_IDLE) && !rst &&
               input_p_tvalid && input_key_tvalid &&
               input_a_tvalid && input_b_tvalid;
   end

   assign input_p_tready   = accept;
   assign input_key_tready = accept;
   assign input_a_tready   = accept;
   assign input_b_tready   = accept;

   assign output_m_tdata  = m_q;
   assign output_m_tvalid = tvalid_q;
   assign output_err      = err_q;

   // p < 3 is tested first, so the wrap of p-2 for tiny p is harmless.
   always_comb begin
      bad_ops = (p_q < SIZE'(3)) ||
                (e_q > (p_q - SIZE'(2))) ||
                (c1_q == '0) ||
                (c1_q >= p_q) ||
                (c2_q >= p_q);
   end

   // Operand selection for the shared multiplier.
   always_comb begin
      mul_x = acc_q;
      mul_y = acc_q;
      case (state_q)
         S_MUL: begin
            mul_x = t_q;
            mul_y = c1_q;
         end
         S_FINAL: begin
            mul_x = c2_q;
            mul_y = acc_q;
         end
         default: begin
            mul_x = acc_q;
            mul_y = acc_q;
         end
      endcase
   end

   // One MSB-first interleaved step. r < p keeps 2r and r+y below 2p, so
   // SIZE+1 bits are enough. After a single conditional subtract the value
   // is below p, which makes the low SIZE bits of the difference exact.
   always_comb begin
      dbl     = {r_q, 1'b0};
      dbl_red = (dbl >= {1'b0, p_q}) ? (dbl[SIZE-1:0] - p_q) : dbl[SIZE-1:0];
      sum     = {1'b0, dbl_red} + {1'b0, mul_y};
      sum_red = (sum >= {1'b0, p_q}) ? (sum[SIZE-1:0] - p_q) : sum[SIZE-1:0];
      r_nxt   = mul_x[cnt_q] ? sum_red : dbl_red;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         p_q      <= '0;
         e_q      <= '0;
         c1_q     <= '0;
         c2_q     <= '0;
         acc_q    <= '0;
         t_q      <= '0;
         u_q      <= '0;
         r_q      <= '0;
         cnt_q    <= '0;
         idx_q    <= '0;
         m_q      <= '0;
         err_q    <= 1'b0;
         tvalid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  p_q     <= input_p_tdata;
                  e_q     <= input_key_tdata;
                  c1_q    <= input_a_tdata;
                  c2_q    <= input_b_tdata;
                  state_q <= S_CHECK;
               end
            end

            S_CHECK: begin
               if (bad_ops) begin
                  m_q      <= '0;
                  err_q    <= 1'b1;
                  tvalid_q <= 1'b1;
                  state_q  <= S_DONE;
               end else begin
                  e_q     <= p_q - SIZE'(1) - e_q;
                  acc_q   <= SIZE'(1);
                  idx_q   <= LAST_BIT;
                  r_q     <= '0;
                  cnt_q   <= LAST_BIT;
                  state_q <= S_SQR;
               end
            end

            S_SQR: begin
               if (cnt_q == '0) begin
                  t_q     <= r_nxt;
                  r_q     <= '0;
                  cnt_q   <= LAST_BIT;
                  state_q <= S_MUL;
               end else begin
                  r_q   <= r_nxt;
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            S_MUL: begin
               if (cnt_q == '0) begin
                  u_q     <= r_nxt;
                  r_q     <= '0;
                  cnt_q   <= LAST_BIT;
                  state_q <= S_NEXT;
               end else begin
                  r_q   <= r_nxt;
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            S_NEXT: begin
               acc_q <= e_q[idx_q] ? u_q : t_q;
               r_q   <= '0;
               cnt_q <= LAST_BIT;
               if (idx_q == '0) begin
                  state_q <= S_FINAL;
               end else begin
                  idx_q   <= idx_q - 1'b1;
                  state_q <= S_SQR;
               end
            end

            S_FINAL: begin
               if (cnt_q == '0) begin
                  m_q      <= r_nxt;
                  err_q    <= 1'b0;
                  tvalid_q <= 1'b1;
                  state_q  <= S_DONE;
               end else begin
                  r_q   <= r_nxt;
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            S_DONE: begin
               if (output_m_tready) begin
                  m_q      <= '0;
                  err_q    <= 1'b0;
                  tvalid_q <= 1'b0;
                  state_q  <= S_IDLE;
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_decrypting_entity.sv
// ---------------------------------------------------------------------------
// tb_decrypting_entity
//   Directed bench for decrypting_entity at SIZE=8 with an expected-result
//   queue filled on acceptance and drained on output handshake.
// ---------------------------------------------------------------------------
module tb_decrypting_entity;

   localparam int SIZE = 8;
   localparam int LAT  = 2*SIZE*SIZE + 2*SIZE + 1;   // 145

   logic            clk = 1'b0;
   logic            rst;
   logic [SIZE-1:0] input_p_tdata, input_key_tdata, input_a_tdata, input_b_tdata;
   logic            input_p_tvalid, input_key_tvalid, input_a_tvalid, input_b_tvalid;
   logic            input_p_tready, input_key_tready, input_a_tready, input_b_tready;
   logic [SIZE-1:0] output_m_tdata;
   logic            output_m_tvalid;
   logic            output_m_tready;
   logic            output_err;

   int ntests = 0;
   int nfail  = 0;
   int cyc    = 0;
   int acc_cyc = 0;
   int hs_cyc  = 0;
   logic [SIZE:0] exp_q[$];   // {err, m}

   decrypting_entity #(.SIZE(SIZE)) dut (
      .clk              (clk),
      .rst              (rst),
      .input_p_tdata    (input_p_tdata),
      .input_p_tvalid   (input_p_tvalid),
      .input_p_tready   (input_p_tready),
      .input_key_tdata  (input_key_tdata),
      .input_key_tvalid (input_key_tvalid),
      .input_key_tready (input_key_tready),
      .input_a_tdata    (input_a_tdata),
      .input_a_tvalid   (input_a_tvalid),
      .input_a_tready   (input_a_tready),
      .input_b_tdata    (input_b_tdata),
      .input_b_tvalid   (input_b_tvalid),
      .input_b_tready   (input_b_tready),
      .output_m_tdata   (output_m_tdata),
      .output_m_tvalid  (output_m_tvalid),
      .output_m_tready  (output_m_tready),
      .output_err       (output_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      ntests++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic set_job(input logic [SIZE-1:0] p, input logic [SIZE-1:0] a,
                          input logic [SIZE-1:0] c1, input logic [SIZE-1:0] c2);
      input_p_tdata    = p;
      input_key_tdata  = a;
      input_a_tdata    = c1;
      input_b_tdata    = c2;
      input_p_tvalid   = 1'b1;
      input_key_tvalid = 1'b1;
      input_a_tvalid   = 1'b1;
      input_b_tvalid   = 1'b1;
   endtask

   task automatic drop_valids();
      input_p_tvalid   = 1'b0;
      input_key_tvalid = 1'b0;
      input_a_tvalid   = 1'b0;
      input_b_tvalid   = 1'b0;
   endtask

   // Called just after a negedge with all valids asserted.
   task automatic accept_job(input logic [SIZE-1:0] exp_m, input logic exp_err);
      int n = 0;
      #1;
      while (!input_p_tready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("accept_timeout", {63'd0, input_p_tready}, 64'd1);
      if (!input_p_tready) begin
         drop_valids();
         return;
      end
      check("tready_joint", {61'd0, input_key_tready, input_a_tready, input_b_tready}, 64'd7);
      exp_q.push_back({exp_err, exp_m});
      @(negedge clk);
      acc_cyc = cyc;
      drop_valids();
      #1;
      check("tready_busy", {63'd0, input_p_tready}, 64'd0);
   endtask

   task automatic wait_out(input int exp_lat);
      int n = 0;
      logic [SIZE:0] e;
      while (!output_m_tvalid && n < LAT + 20) begin
         @(negedge clk);
         n++;
      end
      check("out_timeout", {63'd0, output_m_tvalid}, 64'd1);
      if (!output_m_tvalid) return;
      check("latency", 64'(cyc - acc_cyc), 64'(exp_lat));
      check("queue_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      check("m", 64'(output_m_tdata), 64'(e[SIZE-1:0]));
      check("err", {63'd0, output_err}, {63'd0, e[SIZE]});
   endtask

   task automatic handshake();
      output_m_tready = 1'b1;
      @(negedge clk);
      output_m_tready = 1'b0;
      check("tvalid_cleared", {63'd0, output_m_tvalid}, 64'd0);
      check("tdata_cleared", 64'(output_m_tdata), 64'd0);
      check("err_cleared", {63'd0, output_err}, 64'd0);
   endtask

   task automatic run_job(input logic [SIZE-1:0] p, input logic [SIZE-1:0] a,
                          input logic [SIZE-1:0] c1, input logic [SIZE-1:0] c2,
                          input logic [SIZE-1:0] exp_m, input logic exp_err);
      set_job(p, a, c1, c2);
      accept_job(exp_m, exp_err);
      wait_out(exp_err ? 1 : LAT);
      handshake();
   endtask

   initial begin
      int hi_cnt;
      rst = 1'b1;
      output_m_tready = 1'b0;
      set_job(8'd23, 8'd6, 8'd10, 8'd19);
      #12;
      check("rst_tready", {63'd0, input_p_tready | input_key_tready | input_a_tready | input_b_tready}, 64'd0);
      check("rst_tvalid", {63'd0, output_m_tvalid}, 64'd0);
      check("rst_tdata", 64'(output_m_tdata), 64'd0);
      check("rst_err", {63'd0, output_err}, 64'd0);
      drop_valids();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Main vector
      run_job(8'd23, 8'd6, 8'd10, 8'd19, 8'd7, 1'b0);

      // Staggered valids
      input_p_tdata = 8'd23; input_key_tdata = 8'd6;
      input_a_tdata = 8'd10; input_b_tdata = 8'd19;
      input_p_tvalid = 1'b1;
      hi_cnt = 0;
      repeat (3) begin
         @(negedge clk); #1;
         if (input_p_tready | input_key_tready | input_a_tready | input_b_tready) hi_cnt++;
      end
      input_key_tvalid = 1'b1;
      repeat (5) begin
         @(negedge clk); #1;
         if (input_p_tready | input_key_tready | input_a_tready | input_b_tready) hi_cnt++;
      end
      check("stagger_no_ready", 64'(hi_cnt), 64'd0);
      input_a_tvalid = 1'b1;
      input_b_tvalid = 1'b1;
      accept_job(8'd7, 1'b0);
      wait_out(LAT);
      handshake();

      // Rejected operands
      run_job(8'd23, 8'd22, 8'd10, 8'd19, 8'd0, 1'b1);
      run_job(8'd23, 8'd6,  8'd0,  8'd19, 8'd0, 1'b1);
      run_job(8'd23, 8'd6,  8'd23, 8'd19, 8'd0, 1'b1);
      run_job(8'd2,  8'd0,  8'd1,  8'd1,  8'd0, 1'b1);
      run_job(8'd23, 8'd6,  8'd10, 8'd23, 8'd0, 1'b1);

      // Edge cases
      run_job(8'd23, 8'd6,  8'd10, 8'd0,  8'd0,  1'b0);
      run_job(8'd23, 8'd0,  8'd10, 8'd19, 8'd19, 1'b0);
      run_job(8'd23, 8'd21, 8'd10, 8'd19, 8'd6,  1'b0);   // e=1: 19*10 mod 23
      run_job(8'd23, 8'd21, 8'd22, 8'd22, 8'd1,  1'b0);   // (-1)*(-1)

      // Backpressure then back-to-back
      set_job(8'd23, 8'd6, 8'd10, 8'd19);
      accept_job(8'd7, 1'b0);
      wait_out(LAT);
      set_job(8'd23, 8'd6, 8'd10, 8'd6);
      hi_cnt = 0;
      repeat (20) begin
         @(negedge clk); #1;
         if (!output_m_tvalid || output_m_tdata !== 8'd7 || output_err !== 1'b0) hi_cnt++;
         if (input_p_tready) hi_cnt++;
      end
      check("backpressure_hold", 64'(hi_cnt), 64'd0);
      output_m_tready = 1'b1;
      @(negedge clk);
      hs_cyc = cyc;
      output_m_tready = 1'b0;
      check("b2b_tvalid_cleared", {63'd0, output_m_tvalid}, 64'd0);
      accept_job(8'd1, 1'b0);
      check("b2b_accept_gap", 64'(acc_cyc - hs_cyc), 64'd1);
      wait_out(LAT);
      handshake();

      // Asynchronous reset in the middle of SQR
      set_job(8'd23, 8'd6, 8'd10, 8'd19);
      accept_job(8'd7, 1'b0);
      repeat (20) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_tvalid", {63'd0, output_m_tvalid}, 64'd0);
      check("arst_tdata", 64'(output_m_tdata), 64'd0);
      check("arst_err", {63'd0, output_err}, 64'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      hi_cnt = 0;
      repeat (LAT + 10) begin
         @(negedge clk);
         if (output_m_tvalid) hi_cnt++;
      end
      check("arst_no_pending", 64'(hi_cnt), 64'd0);
      run_job(8'd23, 8'd6, 8'd10, 8'd19, 8'd7, 1'b0);

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
